// File: rtl/ring_cnt_dispatcher.sv
// ring_cnt_dispatcher: queues count jobs and launches them one at a time on a ring counter,
// pulsing job_done_o per completion; optional RUN watchdog enabled by defining RCD_TIMEOUT_EN.
module ring_cnt_dispatcher #(
    parameter int CNT_W       = 8,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid_i,
    input  logic [CNT_W-1:0]         cmd_cnt_i,
    output logic                     cmd_ready_o,
    output logic                     cnt_en_o,
    output logic [CNT_W-1:0]         cnt_num_o,
    input  logic                     cnt_done_i,
    output logic                     job_done_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     timeout_err_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             cnt_en_q;
    logic [CNT_W-1:0] cnt_num_q;
    logic             job_done_q;
    logic             full, empty, push, pop, timeout_hit;
    logic [CNT_W-1:0] head;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign push  = cmd_valid_i && !full;
    assign pop   = (state_q == IDLE) && !empty;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_cnt_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Zero-length jobs complete straight from IDLE without touching the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_en_q   <= 1'b0;
            cnt_num_q  <= '0;
            job_done_q <= 1'b0;
        end else begin
            job_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        if (head != '0) begin
                            cnt_num_q <= head;
                            cnt_en_q  <= 1'b1;
                            state_q   <= RUN;
                        end else begin
                            job_done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cnt_done_i) begin
                        cnt_en_q   <= 1'b0;
                        job_done_q <= 1'b1;
                        state_q    <= GAP;
                    end else if (timeout_hit) begin
                        cnt_en_q <= 1'b0;
                        state_q  <= GAP;
                    end
                end
                GAP:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef RCD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] run_cyc_q;
    logic          timeout_err_q;

    // The count restarts every time RUN is entered; a simultaneous done wins over the timeout.
    assign timeout_hit = (state_q == RUN) && !cnt_done_i && (run_cyc_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cyc_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q != RUN) begin
                run_cyc_q <= '0;
            end else if (!timeout_hit) begin
                run_cyc_q <= run_cyc_q + TW'(1);
            end
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err_o = timeout_err_q;
`else
    assign timeout_hit   = 1'b0;
    // Without the watchdog the limit is meaningless; this expression is constant 0.
    assign timeout_err_o = (TIMEOUT_CYC < 0);
`endif

    assign cmd_ready_o  = !full;
    assign cnt_en_o     = cnt_en_q;
    assign cnt_num_o    = cnt_num_q;
    assign job_done_o   = job_done_q;
    assign busy_o       = (state_q != IDLE) || !empty;
    assign fifo_level_o = level_q;

endmodule

// File: tb/tb_ring_cnt_dispatcher.sv
// Directed bench for ring_cnt_dispatcher with a behavioural ring-counter stand-in and a
// push-order completion scoreboard.
module tb_ring_cnt_dispatcher;
    localparam int CNT_W = 8;
    localparam int DEPTH = 4;
`ifdef RCD_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 1024;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid_i = 1'b0;
    logic [CNT_W-1:0] cmd_cnt_i = '0;
    logic             cmd_ready_o;
    logic             cnt_en_o;
    logic [CNT_W-1:0] cnt_num_o;
    logic             cnt_done_i;
    logic             job_done_o;
    logic             busy_o;
    logic [2:0]       fifo_level_o;
    logic             timeout_err_o;

    ring_cnt_dispatcher #(.CNT_W(CNT_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_cnt_i(cmd_cnt_i), .cmd_ready_o(cmd_ready_o),
        .cnt_en_o(cnt_en_o), .cnt_num_o(cnt_num_o), .cnt_done_i(cnt_done_i),
        .job_done_o(job_done_o), .busy_o(busy_o), .fifo_level_o(fifo_level_o),
        .timeout_err_o(timeout_err_o)
    );

    always #5 clk = ~clk;

    // Counter stand-in: raises done after cnt_num_o enabled cycles, clears when en drops.
    logic ctr_stall = 1'b0;
    logic ctr_done  = 1'b0;
    int   ctr_cnt   = 0;
    always @(posedge clk) begin
        if (!cnt_en_o) begin
            ctr_cnt  <= 0;
            ctr_done <= 1'b0;
        end else if (!ctr_stall) begin
            if (ctr_cnt + 1 >= int'(cnt_num_o)) ctr_done <= 1'b1;
            ctr_cnt <= ctr_cnt + 1;
        end
    end
    assign cnt_done_i = ctr_done;

    // Passive monitor.
    int   done_q[$];
    logic prev_en = 1'b0, prev_done = 1'b0, gap_valid = 1'b0;
    int   low_run = 0, min_gap = 1000, launch_cnt = 0, dbl = 0;
    logic full_seen = 1'b0, full_bad = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_en   <= 1'b0;
            prev_done <= 1'b0;
            low_run   <= 0;
            gap_valid <= 1'b0;
        end else begin
            prev_en   <= cnt_en_o;
            prev_done <= job_done_o;
            low_run   <= cnt_en_o ? 0 : low_run + 1;
            if (cnt_en_o && !prev_en) begin
                launch_cnt <= launch_cnt + 1;
                gap_valid  <= 1'b1;
                if (gap_valid && low_run < min_gap) min_gap <= low_run;
            end
            if (job_done_o) done_q.push_back(prev_en ? int'(cnt_num_o) : 0);
            if (job_done_o && prev_done) dbl <= dbl + 1;
            if (!cmd_ready_o) begin
                full_seen <= 1'b1;
                if (int'(fifo_level_o) != DEPTH) full_bad <= 1'b1;
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int peak  = 0;
    int sb_idx = 0;
    logic [CNT_W-1:0] exp_q[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (int'(fifo_level_o) > peak) peak = int'(fifo_level_o);
    endtask

    task automatic push(input logic [CNT_W-1:0] v);
        int w = 0;
        cmd_valid_i = 1'b1;
        cmd_cnt_i   = v;
        while (!cmd_ready_o && w < 200) begin
            tick();
            w++;
        end
        chk("push_accept", int'(w < 200), 1);
        tick();
        cmd_valid_i = 1'b0;
        exp_q.push_back(v);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((busy_o || cnt_en_o) && k < 2000) begin
            tick();
            k++;
        end
        chk({tag, "_idle"}, int'(k < 2000), 1);
        repeat (3) tick();
    endtask

    task automatic sb_check(input string tag);
        chk({tag, "_njobs"}, done_q.size() - sb_idx, exp_q.size());
        for (int i = 0; i < exp_q.size() && sb_idx + i < done_q.size(); i++)
            chk({tag, "_order"}, done_q[sb_idx + i], int'(exp_q[i]));
        sb_idx = done_q.size();
        exp_q.delete();
    endtask

    initial begin
        int k;
        int snap;

        // Reset state
        #45;
        chk("rst_ready", int'(cmd_ready_o), 1);
        chk("rst_en", int'(cnt_en_o), 0);
        chk("rst_num", int'(cnt_num_o), 0);
        chk("rst_done", int'(job_done_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_level", int'(fifo_level_o), 0);
        chk("rst_terr", int'(timeout_err_o), 0);
        #5 rst = 1'b0;
        tick();

        // Single job of 10
        push(8'd10);
        chk("t1_en_early", int'(cnt_en_o), 0);
        chk("t1_level", int'(fifo_level_o), 1);
        chk("t1_busy", int'(busy_o), 1);
        tick();
        chk("t1_en", int'(cnt_en_o), 1);
        chk("t1_num", int'(cnt_num_o), 10);
        chk("t1_level_pop", int'(fifo_level_o), 0);
        k = 0;
        while (!job_done_o && k < 100) begin
            tick();
            k++;
        end
        chk("t1_done_seen", int'(k < 100), 1);
        chk("t1_en_off", int'(cnt_en_o), 0);
        wait_idle("t1");
        chk("t1_busy_end", int'(busy_o), 0);
        sb_check("t1");

        // Back-to-back 3,5,7
        peak = 0;
        push(8'd3);
        push(8'd5);
        push(8'd7);
        wait_idle("t2");
        chk("t2_peak_ge2", int'(peak >= 2), 1);
        chk("t2_peak_le3", int'(peak <= 3), 1);
        sb_check("t2");

        // Overfill: DEPTH+2 jobs while the first one runs
        peak = 0;
        push(8'd20);
        for (int i = 1; i <= DEPTH + 1; i++) push(CNT_W'(i));
        wait_idle("t3");
        chk("t3_peak", peak, DEPTH);
        chk("t3_full_seen", int'(full_seen), 1);
        chk("t3_full_level", int'(full_bad), 0);
        sb_check("t3");

        // Zero-length job
        snap = launch_cnt;
        push(8'd0);
        chk("t4_done_early", int'(job_done_o), 0);
        tick();
        chk("t4_done", int'(job_done_o), 1);
        chk("t4_en", int'(cnt_en_o), 0);
        tick();
        chk("t4_done_once", int'(job_done_o), 0);
        wait_idle("t4");
        chk("t4_no_launch", launch_cnt, snap);
        sb_check("t4");

        // Reset mid-job
        ctr_stall = 1'b1;
        push(8'd9);
        push(8'd4);
        tick();
        chk("t5_running", int'(cnt_en_o), 1);
        snap = done_q.size();
        rst = 1'b1;
        #1;
        chk("t5_en_rst", int'(cnt_en_o), 0);
        chk("t5_level_rst", int'(fifo_level_o), 0);
        chk("t5_busy_rst", int'(busy_o), 0);
        tick();
        tick();
        rst = 1'b0;
        ctr_stall = 1'b0;
        tick();
        chk("t5_no_done", done_q.size(), snap);
        exp_q.delete();
        push(8'd6);
        tick();
        chk("t5_relaunch_num", int'(cnt_num_o), 6);
        wait_idle("t5");
        sb_check("t5");

        // Watchdog
`ifdef RCD_TIMEOUT_EN
        ctr_stall = 1'b1;
        push(8'd50);
        push(8'd2);
        k = 0;
        while (cnt_en_o && k < 100) begin
            k++;
            tick();
        end
        chk("t6_run_cycles", k, 16);
        chk("t6_terr", int'(timeout_err_o), 1);
        ctr_stall = 1'b0;
        void'(exp_q.pop_front());
        wait_idle("t6");
        chk("t6_terr_sticky", int'(timeout_err_o), 1);
        sb_check("t6");
`else
        ctr_stall = 1'b1;
        push(8'd50);
        repeat (40) tick();
        chk("t6_still_run", int'(cnt_en_o), 1);
        chk("t6_terr_off", int'(timeout_err_o), 0);
        ctr_stall = 1'b0;
        wait_idle("t6");
        chk("t6_terr_off_end", int'(timeout_err_o), 0);
        sb_check("t6");
`endif

        chk("min_en_gap_ge2", int'(min_gap >= 2), 1);
        chk("no_double_pulse", dbl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
